// File: rtl/usb_pkt_rx.sv
// rtl/usb_pkt_rx.sv - USB receive packet decoder: PID and CRC checks, token fields, CRC-stripped payload.
module usb_pkt_rx #(
  parameter int MAX_LEN = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_active,
  input  logic       rx_error,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code
);
  // Wide enough to hold MAX_LEN+2; a byte beyond that sets the overflow flag instead.
  localparam int CW = $clog2(MAX_LEN + 3);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN + 2);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHK, S_DROP} state_t;

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  state_t         state, n_state;
  logic           act_q;
  logic [1:0]     code, n_code, fin_code;
  logic [CW-1:0]  cnt, n_cnt;
  logic           over, n_over;
  logic [4:0]     crc5, n_crc5;
  logic [15:0]    crc16, n_crc16;
  logic [7:0]     dly0, dly1, n_dly0, n_dly1;
  logic [7:0]     tok0, n_tok0;
  logic [2:0]     tok1, n_tok1;
  logic           emit, pid_pass;

  // Effect of this cycle's byte/error, applied before any end-of-packet evaluation.
  always_comb begin
    n_state  = state;
    n_code   = code;
    n_cnt    = cnt;
    n_over   = over;
    n_crc5   = crc5;
    n_crc16  = crc16;
    n_dly0   = dly0;
    n_dly1   = dly1;
    n_tok0   = tok0;
    n_tok1   = tok1;
    emit     = 1'b0;
    pid_pass = 1'b0;
    if (state != S_IDLE) begin
      if (rx_error && state != S_DROP) begin
        n_state = S_DROP;
        if (code == 2'd0) n_code = 2'd3;
      end else if (rx_valid) begin
        case (state)
          S_PID: begin
            if (rx_data[7:4] != ~rx_data[3:0]) begin
              n_state = S_DROP;
              n_code  = 2'd1;
            end else begin
              pid_pass = 1'b1;
              case (rx_data[1:0])
                2'b01:   n_state = S_TOKEN;
                2'b11:   n_state = S_DATA;
                2'b10:   n_state = S_HSHK;
                default: begin
                  n_state = S_DROP;
                  n_code  = 2'd3;
                end
              endcase
            end
          end
          S_TOKEN, S_DATA, S_HSHK: begin
            if (cnt == CNT_MAX) n_over = 1'b1;
            else                n_cnt  = cnt + 1'b1;
            n_crc5  = crc5_byte(crc5, rx_data);
            n_crc16 = crc16_byte(crc16, rx_data);
            if (cnt == CW'(0)) n_tok0 = rx_data;
            if (cnt == CW'(1)) n_tok1 = rx_data[2:0];
            n_dly0 = rx_data;
            n_dly1 = dly0;
            emit   = (state == S_DATA) && (cnt >= CW'(2));
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    fin_code = n_code;
    if (n_code == 2'd0) begin
      case (n_state)
        S_TOKEN: fin_code = (n_cnt != CW'(2)) ? 2'd3 : (n_crc5 != 5'h06) ? 2'd2 : 2'd0;
        S_DATA:  fin_code = (n_cnt < CW'(2) || n_over) ? 2'd3 :
                            (n_crc16 != 16'hB001) ? 2'd2 : 2'd0;
        S_HSHK:  fin_code = (n_cnt != CW'(0)) ? 2'd3 : 2'd0;
        default: fin_code = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      act_q      <= 1'b0;
      code       <= 2'd0;
      cnt        <= '0;
      over       <= 1'b0;
      crc5       <= 5'h1F;
      crc16      <= 16'hFFFF;
      dly0       <= 8'h00;
      dly1       <= 8'h00;
      tok0       <= 8'h00;
      tok1       <= 3'd0;
      pid        <= 4'h0;
      pid_valid  <= 1'b0;
      token_addr <= 7'h00;
      token_endp <= 4'h0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      act_q     <= rx_active;
      pid_valid <= pid_pass;
      if (pid_pass) pid <= rx_data[3:0];
      out_valid <= emit;
      if (emit) out_data <= dly1;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= 2'd0;
      dly0      <= n_dly0;
      dly1      <= n_dly1;
      tok0      <= n_tok0;
      tok1      <= n_tok1;
      if (state == S_IDLE) begin
        code  <= 2'd0;
        cnt   <= '0;
        over  <= 1'b0;
        crc5  <= 5'h1F;
        crc16 <= 16'hFFFF;
        if (rx_active && !act_q) state <= S_PID;
      end else if (!rx_active) begin
        state <= S_IDLE;
        if (fin_code == 2'd0) begin
          pkt_ok <= 1'b1;
          if (n_state == S_TOKEN) begin
            token_addr <= n_tok0[6:0];
            token_endp <= {n_tok1, n_tok0[7]};
          end
        end else begin
          pkt_err  <= 1'b1;
          err_code <= fin_code;
        end
      end else begin
        state <= n_state;
        code  <= n_code;
        cnt   <= n_cnt;
        over  <= n_over;
        crc5  <= n_crc5;
        crc16 <= n_crc16;
      end
    end
  end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb/tb_usb_pkt_rx.sv - Self-checking bench for usb_pkt_rx with a packet-level reference model.
module tb_usb_pkt_rx;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error;
  logic [3:0] pid;
  logic       pid_valid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic [7:0] out_data;
  logic       out_valid, pkt_ok, pkt_err;
  logic [1:0] err_code;

  usb_pkt_rx #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .pid_valid(pid_valid),
    .token_addr(token_addr), .token_endp(token_endp), .out_data(out_data),
    .out_valid(out_valid), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_ok = 0, n_err = 0, n_pidv = 0, n_both = 0;
  logic [1:0] last_code = 2'd0;
  logic [3:0] last_pid = 4'h0;
  logic [7:0] got_q[$];
  logic [7:0] tx_q[$];
  logic [6:0] cur_addr = 7'h00;
  logic [3:0] cur_endp = 4'h0;
  logic [7:0] tok_pids[4]  = '{8'hE1, 8'h69, 8'h2D, 8'hA5};
  logic [7:0] dat_pids[4]  = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
  logic [7:0] hs_pids[4]   = '{8'hD2, 8'h5A, 8'h1E, 8'h96};
  logic [7:0] spc_pids[4]  = '{8'h3C, 8'h78, 8'hB4, 8'hF0};

  always @(negedge clk) begin
    if (out_valid) got_q.push_back(out_data);
    if (pid_valid) begin n_pidv++; last_pid = pid; end
    if (pkt_ok) n_ok++;
    if (pkt_err) begin n_err++; last_code = err_code; end
    if (pkt_ok && pkt_err) n_both++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] crc5_field(input logic [10:0] f);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return c;
  endfunction

  function automatic logic [15:0] crc16_q(input int lo, input int cnt);
    logic [15:0] c = 16'hFFFF;
    for (int j = lo; j < lo + cnt; j++)
      for (int i = 0; i < 8; i++) c = (c[0] ^ tx_q[j][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  task automatic build_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e,
                             input logic [15:0] flip);
    logic [10:0] f;
    logic [15:0] w;
    f = {e, a};
    w = {~crc5_field(f), f} ^ flip;
    tx_q.delete();
    tx_q.push_back(p);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
  endtask

  task automatic build_data(input logic [7:0] p, input int len, input logic [15:0] flip,
                            input logic seq);
    logic [15:0] c;
    tx_q.delete();
    tx_q.push_back(p);
    for (int i = 0; i < len; i++) tx_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
    c = ~crc16_q(1, len) ^ flip;
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
  endtask

  // Packet-level expectation: outcome, cause and how many payload bytes get forwarded.
  task automatic model(input int err_after, output logic ok, output logic [1:0] code,
                       output int nfwd, output logic tok);
    int n, k, m;
    logic [7:0] p;
    logic errf;
    n = tx_q.size();
    errf = (err_after >= 0);
    k = (errf && err_after < n) ? err_after : n;
    code = 2'd0; nfwd = 0; tok = 1'b0;
    p = (n > 0) ? tx_q[0] : 8'h00;
    if (n == 0 || (errf && k == 0)) code = 2'd3;
    else if (p[7:4] != ~p[3:0]) code = 2'd1;
    else if (p[1:0] == 2'b00) code = 2'd3;
    else if (errf) begin
      code = 2'd3;
      if (p[1:0] == 2'b11 && k > 3) nfwd = k - 3;
    end else begin
      m = n - 1;
      case (p[1:0])
        2'b01: begin
          tok = 1'b1;
          if (m != 2) code = 2'd3;
          else if (~crc5_field({tx_q[2][2:0], tx_q[1]}) != tx_q[2][7:3]) code = 2'd2;
        end
        2'b11: begin
          nfwd = (m > 2) ? m - 2 : 0;
          if (m < 2 || m - 2 > MAXL) code = 2'd3;
          else if (~crc16_q(1, m - 2) != {tx_q[n-1], tx_q[n-2]}) code = 2'd2;
        end
        default: if (m != 0) code = 2'd3;
      endcase
    end
    ok = (code == 2'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input string tag, input int err_after, input int hold);
    int b_ok, b_err, b_pidv, b_got, nfwd;
    logic ok, tok, pidpass;
    logic [1:0] code;
    b_ok = n_ok; b_err = n_err; b_pidv = n_pidv; b_got = got_q.size();
    model(err_after, ok, code, nfwd, tok);
    pidpass = (tx_q[0][7:4] == ~tx_q[0][3:0]);
    repeat (2) @(posedge clk);
    #1 rx_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      if (i + 1 == err_after) begin
        rx_error = 1'b1;
        @(posedge clk); #1 rx_error = 1'b0;
      end
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 chk({tag, ".hold_no_pulse"}, n_ok + n_err, b_ok + b_err);
    end
    rx_active = 1'b0;
    @(negedge clk);
    chk({tag, ".eop_early"}, 32'(pkt_ok | pkt_err), 0);
    @(negedge clk);
    chk({tag, ".eop_pulse"}, 32'(pkt_ok | pkt_err), 1);
    repeat (2) @(posedge clk);
    #1;
    if (ok && tok) begin
      cur_addr = tx_q[1][6:0];
      cur_endp = {tx_q[2][2:0], tx_q[1][7]};
    end
    chk({tag, ".pulses"}, (n_ok - b_ok) + (n_err - b_err), 1);
    chk({tag, ".ok"}, n_ok - b_ok, 32'(ok));
    if (!ok) chk({tag, ".code"}, last_code, code);
    chk({tag, ".pidv"}, n_pidv - b_pidv, 32'(pidpass));
    if (pidpass) chk({tag, ".pid"}, last_pid, tx_q[0][3:0]);
    chk({tag, ".nfwd"}, got_q.size() - b_got, nfwd);
    for (int i = 0; i < nfwd && b_got + i < got_q.size(); i++)
      chk({tag, ".byte"}, got_q[b_got + i], tx_q[1 + i]);
    chk({tag, ".tok_fields"}, {token_endp, token_addr}, {cur_endp, cur_addr});
  endtask

  initial begin
    int kind, b, ea;
    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pid, pid_valid, token_addr, token_endp, out_data, out_valid,
                          pkt_ok, pkt_err, err_code}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    tx_q = '{8'h2D, 8'h00, 8'h10};               run_pkt("setup", -1, 0);
    tx_q = '{8'hC3, 8'h00, 8'h00};               run_pkt("data0_zlp", -1, 0);
    tx_q = '{8'h4B, 8'h00, 8'h00};               run_pkt("data1_zlp", -1, 0);
    build_data(8'hC3, 8, 16'h0000, 1'b1);        run_pkt("data0_8", -1, 0);
    build_data(8'hC3, 8, 16'h0100, 1'b1);        run_pkt("data0_8_badcrc", -1, 0);
    tx_q = '{8'hD2};                             run_pkt("ack", -1, 0);
    tx_q = '{8'h5B, 8'h00, 8'h11};               run_pkt("bad_pid", -1, 0);
    tx_q = '{8'h3C};                             run_pkt("pre", -1, 0);
    tx_q = '{8'h2D, 8'h00};                      run_pkt("token_short", -1, 0);
    tx_q = '{8'hC3, 8'h11, 8'h22, 8'h33};        run_pkt("rx_error_hold", 4, 50);
    build_token(8'h69, 7'h55, 4'hA, 16'h0000);   run_pkt("in_token", -1, 0);
    build_data(8'h4B, MAXL, 16'h0000, 1'b0);     run_pkt("data_maxlen", -1, 0);
    build_data(8'h4B, MAXL + 1, 16'h0000, 1'b0); run_pkt("data_overlen", -1, 0);

    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          build_token(tok_pids[$urandom_range(0, 3)], 7'($urandom), 4'($urandom),
                      ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
          if ($urandom_range(0, 7) == 0) void'(tx_q.pop_back());
        end
        1: build_data(dat_pids[$urandom_range(0, 3)], $urandom_range(0, MAXL + 2),
                      ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0,
                      1'b0);
        2: begin
          tx_q = '{hs_pids[$urandom_range(0, 3)]};
          if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom));
        end
        3: begin
          tx_q = '{8'($urandom)};
          for (int i = 0; i < $urandom_range(0, 2); i++) tx_q.push_back(8'($urandom));
        end
        default: tx_q = '{spc_pids[$urandom_range(0, 3)]};
      endcase
      ea = ($urandom_range(0, 7) == 0) ? $urandom_range(1, tx_q.size()) : -1;
      run_pkt("random", ea, 0);
    end

    repeat (2) @(posedge clk);
    #1 rx_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    b = n_ok + n_err;
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk("reset_mid_outputs", {pid, pid_valid, token_addr, token_endp, out_data, out_valid,
                                 pkt_ok, pkt_err, err_code}, 0);
    rx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cur_addr = 7'h00; cur_endp = 4'h0;
    repeat (3) @(posedge clk);
    #1 chk("reset_no_pulse", n_ok + n_err, b);
    tx_q = '{8'hD2};
    run_pkt("ack_after_reset", -1, 0);

    chk("never_both", n_both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
